// File: rtl/machine_button_conditioner_pkg.sv
// Shared constants and state encoding for the push-button conditioner.
package machine_button_conditioner_pkg;

    // Default timing for a 1 kHz system clock.
    localparam int unsigned DEBOUNCE_CYCLES_1KHZ = 1;
    localparam int unsigned REPEAT_DELAY_1KHZ    = 25;
    localparam int unsigned REPEAT_RATE_1KHZ     = 5;

    // Default timing for a 1000 MHz system clock.
    localparam int unsigned DEBOUNCE_CYCLES_1GHZ = 50000;
    localparam int unsigned REPEAT_DELAY_1GHZ    = 25000000;
    localparam int unsigned REPEAT_RATE_1GHZ     = 5000000;

    // Per-channel edge/auto-repeat state.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDelay  = 2'd1,
        StRepeat = 2'd2,
        StHeld   = 2'd3
    } btn_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/machine_button_channel.sv
// One button channel: synchroniser, debouncer and edge/auto-repeat FSM.
module machine_button_channel
    import machine_button_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_1GHZ,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_1GHZ,
    parameter int unsigned REPEAT_RATE     = REPEAT_RATE_1GHZ
) (
    input  logic system1000,
    input  logic system1000_rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);

    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RPT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_RATE) + 1);

    localparam logic [DEB_W-1:0] DEB_TERM   = DEB_W'(DEBOUNCE_CYCLES - 1);
    // Unreachable when REPEAT_DELAY is 0 (the FSM goes straight to HELD).
    localparam logic [RPT_W-1:0] DELAY_TERM = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_TERM  = RPT_W'(REPEAT_RATE - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DEB_W-1:0]       r_cnt;
    logic                   r_level;
    logic [RPT_W-1:0]       r_rpt;
    btn_state_e             r_state;
    logic                   r_pulse;

    logic w_s;
    logic w_level_d;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Shift the raw asynchronous input through the synchroniser chain.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
        end
    end

    // Next debounced level, so the FSM can pulse in the same cycle the level rises.
    always_comb begin
        w_level_d = r_level;
        if ((w_s != r_level) && (r_cnt == DEB_TERM)) begin
            w_level_d = w_s;
        end
    end

    // Accept a new level only after it has been stable for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (w_s == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == DEB_TERM) begin
            r_level <= w_s;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + DEB_W'(1);
        end
    end

    // Edge/auto-repeat FSM with a registered one-cycle pulse output.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            r_state <= StIdle;
            r_rpt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (!w_level_d) begin
                // Release drops any pending repeat.
                r_state <= StIdle;
                r_rpt   <= '0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (!r_level) begin
                            r_pulse <= 1'b1;
                            r_rpt   <= '0;
                            r_state <= (REPEAT_DELAY == 0) ? StHeld : StDelay;
                        end
                    end
                    StDelay: begin
                        if (r_rpt == DELAY_TERM) begin
                            // Guard keeps pulses at least one cycle apart for tiny settings.
                            r_pulse <= !r_pulse;
                            r_rpt   <= '0;
                            r_state <= StRepeat;
                        end else begin
                            r_rpt <= r_rpt + RPT_W'(1);
                        end
                    end
                    StRepeat: begin
                        if (r_rpt == RATE_TERM) begin
                            r_pulse <= !r_pulse;
                            r_rpt   <= '0;
                        end else begin
                            r_rpt <= r_rpt + RPT_W'(1);
                        end
                    end
                    StHeld: begin
                        r_rpt <= '0;
                    end
                    default: begin
                        r_state <= StIdle;
                        r_rpt   <= '0;
                    end
                endcase
            end
        end
    end

    assign btn_level = r_level;
    assign btn_pulse = r_pulse;

endmodule

// File: rtl/machine_button_conditioner.sv
// Conditions NBTN raw push-buttons into debounced levels and auto-repeating step pulses.
module machine_button_conditioner
    import machine_button_conditioner_pkg::*;
#(
    parameter int unsigned NBTN            = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_1GHZ,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_1GHZ,
    parameter int unsigned REPEAT_RATE     = REPEAT_RATE_1GHZ
) (
    input  logic            system1000,
    input  logic            system1000_rst,
    input  logic [NBTN-1:0] btn_raw,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_pulse
);

    for (genvar g = 0; g < NBTN; g++) begin : g_chan
        machine_button_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_chan (
            .system1000     (system1000),
            .system1000_rst (system1000_rst),
            .btn_raw        (btn_raw[g]),
            .btn_level      (btn_level[g]),
            .btn_pulse      (btn_pulse[g])
        );
    end

endmodule

// File: tb/tb_machine_button_conditioner.sv
// Directed bench for machine_button_conditioner with short debounce/repeat timing.
module tb_machine_button_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] pls;
    logic [3:0] raw_b;
    logic [3:0] lvl_b;
    logic [3:0] pls_b;
    logic [7:0] addr;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] raw;
        logic [3:0] lvl;
        logic [3:0] pls;
    } vec_t;

    vec_t vecs[40];

    always #5 clk = ~clk;

    machine_button_conditioner #(
        .NBTN            (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_RATE     (3)
    ) u_dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .btn_raw        (raw),
        .btn_level      (lvl),
        .btn_pulse      (pls)
    );

    machine_button_conditioner #(
        .NBTN            (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (0),
        .REPEAT_RATE     (3)
    ) u_dut_norpt (
        .system1000     (clk),
        .system1000_rst (rst),
        .btn_raw        (raw_b),
        .btn_level      (lvl_b),
        .btn_pulse      (pls_b)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock, sample just after the edge, and update the selector model.
    task automatic step();
        @(posedge clk);
        #1;
        if (pls[2] && !pls[3]) addr = addr + 8'd1;
        else if (pls[3] && !pls[2]) addr = addr - 8'd1;
    endtask

    initial begin
        int cnt;
        rst   = 1'b1;
        raw   = 4'hF;
        raw_b = 4'hF;
        addr  = 8'h40;

        // Case 1: reset held with all buttons pressed.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_level", {4'h0, lvl}, 8'h00);
            check("rst_pulse", {4'h0, pls}, 8'h00);
            check("rst_level_b", {4'h0, lvl_b}, 8'h00);
        end
        rst   = 1'b0;
        raw   = 4'h0;
        raw_b = 4'h0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("idle_level", {4'h0, lvl}, 8'h00);
        end

        // Case 2: press btn 2 at cycle 0, release at cycle 25.
        for (int k = 0; k < 40; k++) begin
            int c;
            c = k + 1;
            vecs[k].raw = (c <= 25) ? 4'h4 : 4'h0;
            vecs[k].lvl = (c >= 6 && c < 31) ? 4'h4 : 4'h0;
            vecs[k].pls = (c == 6 || c == 16 || c == 19 || c == 22 || c == 25 || c == 28)
                          ? 4'h4 : 4'h0;
        end
        for (int k = 0; k < 40; k++) begin
            raw = vecs[k].raw;
            step();
            check($sformatf("c2_level[%0d]", k + 1), {4'h0, lvl}, {4'h0, vecs[k].lvl});
            check($sformatf("c2_pulse[%0d]", k + 1), {4'h0, pls}, {4'h0, vecs[k].pls});
        end

        // Case 3: bouncing btn 3 never settles long enough.
        for (int i = 0; i < 20; i++) begin
            raw = ((i >> 1) & 1) != 0 ? 4'h8 : 4'h0;
            step();
            check("c3_level", {4'h0, lvl}, 8'h00);
            check("c3_pulse", {4'h0, pls}, 8'h00);
        end
        raw = 4'h0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("c3_settle", {4'h0, lvl | pls}, 8'h00);
        end

        // Case 4: both step buttons together pulse together; selector holds.
        addr = 8'h40;
        raw  = 4'hC;
        for (int c = 1; c <= 20; c++) begin
            step();
            check($sformatf("c4_pulse[%0d]", c), {4'h0, pls},
                  (c == 6 || c == 16 || c == 19) ? 8'h0C : 8'h00);
        end
        raw = 4'h0;
        for (int i = 0; i < 12; i++) step();
        check("c4_addr", addr, 8'h40);
        check("c4_level_off", {4'h0, lvl}, 8'h00);

        // Case 5: reset during the repeat delay with the button held.
        raw = 4'h4;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 6) check("c5_first", {4'h0, pls}, 8'h04);
        end
        rst = 1'b1;
        for (int c = 13; c <= 14; c++) begin
            step();
            check("c5_rst_level", {4'h0, lvl}, 8'h00);
            check("c5_rst_pulse", {4'h0, pls}, 8'h00);
        end
        rst = 1'b0;
        for (int c = 15; c <= 20; c++) begin
            step();
            check($sformatf("c5_pulse[%0d]", c), {4'h0, pls}, (c == 20) ? 8'h04 : 8'h00);
            check($sformatf("c5_level[%0d]", c), {4'h0, lvl}, (c == 20) ? 8'h04 : 8'h00);
        end
        raw = 4'h0;
        for (int i = 0; i < 12; i++) step();
        check("c5_level_off", {4'h0, lvl}, 8'h00);

        // Case 6: auto-repeat disabled build.
        raw_b = 4'h1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (pls_b[0]) cnt++;
        end
        check("c6_hold_pulses", cnt[7:0], 8'd1);
        check("c6_level", {4'h0, lvl_b}, 8'h01);
        raw_b = 4'h0;
        for (int i = 0; i < 15; i++) step();
        check("c6_release_level", {4'h0, lvl_b}, 8'h00);
        raw_b = 4'h1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (pls_b[0]) cnt++;
        end
        check("c6_repress_pulses", cnt[7:0], 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
